countdown_timer_ctrl: RTL and testbench

//  Parametrised mm:ss kitchen-timer controller for the DE-board top level.
//  - Captures the preset from the switches. Start/stop comes from the keys.
//  - Counts down at 1 Hz derived from CLOCK_50 and drives four 7-seg digits.
//  - Flashes LEDR on expiry.
//  - Supersedes the fixed-code state machine: adds real timekeeping, key edge detection and BCD clamping.

---
 rtl/countdown_timer_ctrl_if.sv | 14 +
 rtl/countdown_timer_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_countdown_timer_ctrl.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/countdown_timer_ctrl_if.sv
// Board-facing signals of the mm:ss kitchen timer.
// master drives switches/keys (board or bench), slave is the timer controller.
interface countdown_timer_ctrl_if #(
    parameter int LED_WIDTH = 10
);
    logic [7:0]           SW;
    logic [1:0]           KEY;
    logic [LED_WIDTH-1:0] LEDR;
    logic [6:0]           HEX0, HEX1, HEX2, HEX3;
    logic [2:0]           state;

    modport master (output SW, KEY, input LEDR, HEX0, HEX1, HEX2, HEX3, state);
    modport slave  (input SW, KEY, output LEDR, HEX0, HEX1, HEX2, HEX3, state);
endinterface

// File: rtl/countdown_timer_ctrl.sv
// mm:ss countdown timer controller: key sync/edge detect, BCD preset with
// clamping, 1 Hz countdown, 7-seg display and LEDR flash on expiry.
// Optional macro TIMER_STATUS_LEDR_EN: outside FLASH, LEDR shows the state
// code on [2:0] and a one-cycle tick marker on the top bit.
module countdown_timer_ctrl #(
    parameter int CLK_HZ      = 50_000_000,
    parameter int FLASH_DIV   = 12_500_000,
    parameter int LED_WIDTH   = 10,
    parameter int SYNC_STAGES = 2
) (
    input  logic                         CLOCK_50,
    input  logic                         reset,
    countdown_timer_ctrl_if.slave        io
);
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SET_SEC = 3'd1,
        SET_MIN = 3'd2,
        STOPPED = 3'd3,
        RUNNING = 3'd4,
        FLASH   = 3'd5
    } state_t;

    localparam int PW = $clog2(CLK_HZ + 1);
    localparam int FW = $clog2(FLASH_DIV + 1);
    localparam logic [PW-1:0] PRE_LAST = PW'(CLK_HZ - 1);
    localparam logic [FW-1:0] FL_LAST  = FW'(FLASH_DIV - 1);

    state_t                       state_q;
    logic [15:0]                  tm_q;      // {mm tens, mm ones, ss tens, ss ones}
    logic [15:0]                  tm_dec;
    logic [PW-1:0]                pre_q;
    logic [FW-1:0]                fdiv_q;
    logic [LED_WIDTH-1:0]         flash_q;
    logic [1:0][SYNC_STAGES-1:0]  key_sync;
    logic [1:0]                   key_prev;
    logic                         set_p, tog_p;
    logic [LED_WIDTH-1:0]         led;
`ifdef TIMER_STATUS_LEDR_EN
    logic                         tick_q;
`endif

    function automatic logic [7:0] clamp_bcd(input logic [7:0] sw);
        logic [3:0] t, o;
        t = (sw[7:4] > 4'd5) ? 4'd5 : sw[7:4];
        o = (sw[3:0] > 4'd9) ? 4'd9 : sw[3:0];
        return {t, o};
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h40;
            4'd1:    return 7'h79;
            4'd2:    return 7'h24;
            4'd3:    return 7'h30;
            4'd4:    return 7'h19;
            4'd5:    return 7'h12;
            4'd6:    return 7'h02;
            4'd7:    return 7'h78;
            4'd8:    return 7'h00;
            default: return 7'h10;
        endcase
    endfunction

    // Key synchronisers (idle high) plus previous sample for falling-edge detect.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            key_sync <= '1;
            key_prev <= '1;
        end else begin
            for (int k = 0; k < 2; k++) begin
                key_sync[k] <= {key_sync[k][SYNC_STAGES-2:0], io.KEY[k]};
                key_prev[k] <= key_sync[k][SYNC_STAGES-1];
            end
        end
    end

    // A press is a released->pressed transition at the synchroniser output.
    assign set_p = key_prev[0] & ~key_sync[0][SYNC_STAGES-1];
    assign tog_p = key_prev[1] & ~key_sync[1][SYNC_STAGES-1];

    // BCD borrow chain for one-second decrement; only used while time is non-zero.
    always_comb begin
        tm_dec = tm_q;
        if (tm_q[3:0] != 4'd0) begin
            tm_dec[3:0] = tm_q[3:0] - 4'd1;
        end else begin
            tm_dec[3:0] = 4'd9;
            if (tm_q[7:4] != 4'd0) begin
                tm_dec[7:4] = tm_q[7:4] - 4'd1;
            end else begin
                tm_dec[7:4] = 4'd5;
                if (tm_q[11:8] != 4'd0) begin
                    tm_dec[11:8] = tm_q[11:8] - 4'd1;
                end else begin
                    tm_dec[11:8]  = 4'd9;
                    tm_dec[15:12] = tm_q[15:12] - 4'd1;
                end
            end
        end
    end

    // Main controller: state, time digits, prescaler and flash divider.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q <= IDLE;
            tm_q    <= '0;
            pre_q   <= '0;
            fdiv_q  <= '0;
            flash_q <= '0;
`ifdef TIMER_STATUS_LEDR_EN
            tick_q  <= 1'b0;
`endif
        end else begin
`ifdef TIMER_STATUS_LEDR_EN
            tick_q <= 1'b0;
`endif
            case (state_q)
                IDLE: state_q <= SET_SEC;
                SET_SEC: if (set_p) begin
                    tm_q[7:0] <= clamp_bcd(io.SW);
                    state_q   <= SET_MIN;
                end
                SET_MIN: if (set_p) begin
                    tm_q[15:8] <= clamp_bcd(io.SW);
                    state_q    <= STOPPED;
                end
                STOPPED: begin
                    if (set_p)                       state_q <= SET_SEC;
                    else if (tog_p && tm_q != 16'd0) state_q <= RUNNING;
                end
                RUNNING: begin
                    // Stopping holds the prescaler so a restart resumes mid-second.
                    if (tog_p) begin
                        state_q <= STOPPED;
                    end else if (pre_q == PRE_LAST) begin
                        pre_q <= '0;
                        tm_q  <= tm_dec;
`ifdef TIMER_STATUS_LEDR_EN
                        tick_q <= 1'b1;
`endif
                        if (tm_dec == 16'd0) state_q <= FLASH;
                    end else begin
                        pre_q <= pre_q + 1'b1;
                    end
                end
                FLASH: begin
                    if (set_p || tog_p) begin
                        state_q <= SET_SEC;
                        fdiv_q  <= '0;
                        flash_q <= '0;
                    end else if (fdiv_q == FL_LAST) begin
                        fdiv_q  <= '0;
                        flash_q <= ~flash_q;
                    end else begin
                        fdiv_q <= fdiv_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // LEDR: flash pattern in FLASH (flash_q is zero everywhere else).
`ifdef TIMER_STATUS_LEDR_EN
    always_comb begin
        led = flash_q;
        if (state_q != FLASH) begin
            led                = '0;
            led[2:0]           = state_q;
            led[LED_WIDTH-1]   = tick_q;
        end
    end
`else
    assign led = flash_q;
`endif

    assign io.LEDR  = led;
    assign io.state = state_q;
    assign io.HEX0  = seg7(tm_q[3:0]);
    assign io.HEX1  = seg7(tm_q[7:4]);
    assign io.HEX2  = seg7(tm_q[11:8]);
    assign io.HEX3  = seg7(tm_q[15:12]);

endmodule

// File: tb/tb_countdown_timer_ctrl.sv
// Bench for countdown_timer_ctrl: seconds-based behavioural model checked every
// cycle, plus directed key/switch sequences with literal expectations.
module tb_countdown_timer_ctrl;
    localparam int CLK_HZ = 10;
    localparam int FLASH_DIV = 3;
    localparam int SYNC = 2;
    localparam int LW = 10;

    logic clk = 1'b0;
    logic rst;
    int   n_chk = 0;
    int   n_fail = 0;

    countdown_timer_ctrl_if #(.LED_WIDTH(LW)) bus ();

    countdown_timer_ctrl #(
        .CLK_HZ(CLK_HZ), .FLASH_DIV(FLASH_DIV), .LED_WIDTH(LW), .SYNC_STAGES(SYNC)
    ) dut (
        .CLOCK_50(clk),
        .reset(rst),
        .io(bus)
    );

    always #5 clk = ~clk;

    wire [27:0] hex_w = {bus.HEX3, bus.HEX2, bus.HEX1, bus.HEX0};

`ifdef TIMER_STATUS_LEDR_EN
    localparam logic [LW-1:0] LED_IN_SET_SEC = 10'h001;
`else
    localparam logic [LW-1:0] LED_IN_SET_SEC = 10'h000;
`endif

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] seg(input int d);
        case (d)
            0: return 7'h40; 1: return 7'h79; 2: return 7'h24; 3: return 7'h30;
            4: return 7'h19; 5: return 7'h12; 6: return 7'h02; 7: return 7'h78;
            8: return 7'h00; default: return 7'h10;
        endcase
    endfunction

    // Behavioural model: time as plain seconds, keys as a sample history.
    int           m_st, m_secs, m_pres, m_fcnt;
    logic [LW-1:0] m_led;
    bit           m_tick;
    bit           mvalid = 0;
    logic [1:0]   m_hist [0:SYNC];

    always @(posedge clk) begin
        bit sp, tp;
        int v, t, o;
        if (rst) begin
            m_st = 0; m_secs = 0; m_pres = 0; m_fcnt = 0; m_led = '0; m_tick = 0;
            for (int i = 0; i <= SYNC; i++) m_hist[i] = 2'b11;
            mvalid = 1;
        end else if (mvalid) begin
            sp = m_hist[SYNC][0] && !m_hist[SYNC-1][0];
            tp = m_hist[SYNC][1] && !m_hist[SYNC-1][1];
            for (int i = SYNC; i > 0; i--) m_hist[i] = m_hist[i-1];
            m_hist[0] = bus.KEY;
            m_tick = 0;
            t = (int'(bus.SW[7:4]) > 5) ? 5 : int'(bus.SW[7:4]);
            o = (int'(bus.SW[3:0]) > 9) ? 9 : int'(bus.SW[3:0]);
            v = t * 10 + o;
            case (m_st)
                0: m_st = 1;
                1: if (sp) begin m_secs = (m_secs / 60) * 60 + v; m_st = 2; end
                2: if (sp) begin m_secs = v * 60 + m_secs % 60; m_st = 3; end
                3: if (sp) m_st = 1; else if (tp && m_secs > 0) m_st = 4;
                4: if (tp) m_st = 3;
                   else begin
                       m_pres++;
                       if (m_pres == CLK_HZ) begin
                           m_pres = 0; m_secs--; m_tick = 1;
                           if (m_secs == 0) m_st = 5;
                       end
                   end
                5: if (sp || tp) begin m_st = 1; m_fcnt = 0; m_led = '0; end
                   else begin
                       m_fcnt++;
                       if (m_fcnt == FLASH_DIV) begin m_fcnt = 0; m_led = ~m_led; end
                   end
                default: m_st = 0;
            endcase
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        logic [LW-1:0] exp_led;
        int ss, mm;
        if (mvalid) begin
            ss = m_secs % 60;
            mm = m_secs / 60;
`ifdef TIMER_STATUS_LEDR_EN
            exp_led = (m_st == 5) ? m_led : ((m_tick ? 10'h200 : 10'h000) | LW'(m_st));
`else
            exp_led = m_led;
`endif
            chk("model_state", 32'(bus.state), 32'(m_st));
            chk("model_hex", 32'(hex_w), 32'({seg(mm / 10), seg(mm % 10), seg(ss / 10), seg(ss % 10)}));
            chk("model_ledr", 32'(bus.LEDR), 32'(exp_led));
        end
    end

    task automatic press(input int k);
        bus.KEY[k] = 1'b0;
        repeat (4) @(negedge clk);
        bus.KEY[k] = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic wait_state(input int s, input int lim, input string nm);
        int n = 0;
        while (bus.state !== 3'(s) && n < lim) begin
            @(negedge clk);
            n++;
        end
        chk(nm, 32'(bus.state), 32'(s));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bus.SW = 8'h00; bus.KEY = 2'b11; rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_state", 32'(bus.state), 0);
        chk("reset_hex", 32'(hex_w), 32'({4{7'h40}}));
        chk("reset_ledr", 32'(bus.LEDR), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_to_set_sec", 32'(bus.state), 1);

        bus.SW = 8'h05; press(0);
        bus.SW = 8'h01; press(0);
        chk("preset_state", 32'(bus.state), 3);
        chk("preset_0105", 32'(hex_w), 32'({7'h40, 7'h79, 7'h40, 7'h12}));

        press(0); bus.SW = 8'hFF; press(0); press(0);
        chk("clamp_5959", 32'(hex_w), 32'({7'h12, 7'h10, 7'h12, 7'h10}));
        press(0); bus.SW = 8'hF3; press(0); bus.SW = 8'h01; press(0);
        chk("clamp_0153", 32'(hex_w), 32'({7'h40, 7'h79, 7'h12, 7'h30}));
        press(0); bus.SW = 8'h05; press(0); bus.SW = 8'h01; press(0);

        press(1);
        chk("run_state", 32'(bus.state), 4);
        repeat (4) @(negedge clk);
        chk("before_first_tick", 32'(hex_w), 32'({7'h40, 7'h79, 7'h40, 7'h12}));
        @(negedge clk);
        chk("first_tick_0104", 32'(hex_w), 32'({7'h40, 7'h79, 7'h40, 7'h19}));

        repeat (3) @(negedge clk);
        press(1);
        chk("stopped_state", 32'(bus.state), 3);
        repeat (50) @(negedge clk);
        chk("frozen_0104", 32'(hex_w), 32'({7'h40, 7'h79, 7'h40, 7'h19}));
        press(1);
        wait_state(5, 1500, "expire_to_flash");
        chk("expire_hex", 32'(hex_w), 32'({4{7'h40}}));

        n = 0;
        while (bus.LEDR !== 10'h3FF && n < 10) begin @(negedge clk); n++; end
        chk("flash_on", 32'(bus.LEDR), 32'h3FF);
        repeat (3) @(negedge clk);
        chk("flash_off", 32'(bus.LEDR), 0);
        press(0);
        chk("flash_exit_state", 32'(bus.state), 1);
        chk("flash_exit_ledr", 32'(bus.LEDR), 32'(LED_IN_SET_SEC));

        bus.SW = 8'h30; press(0); bus.SW = 8'h00; press(0);
        chk("stopped_0030", 32'(bus.state), 3);
        bus.KEY = 2'b00;
        repeat (4) @(negedge clk);
        bus.KEY = 2'b11;
        repeat (4) @(negedge clk);
        chk("both_keys_stopped", 32'(bus.state), 1);

        bus.SW = 8'h00; press(0); press(0);
        press(1);
        chk("tog_at_zero_stays", 32'(bus.state), 3);

        press(0); bus.SW = 8'h30; press(0); bus.SW = 8'h00; press(0);
        press(1);
        chk("run2_state", 32'(bus.state), 4);
        chk("run2_0030", 32'(hex_w), 32'({7'h40, 7'h40, 7'h30, 7'h40}));
        rst = 1'b1;
        @(negedge clk);
        chk("midrun_reset_state", 32'(bus.state), 0);
        chk("midrun_reset_hex", 32'(hex_w), 32'({4{7'h40}}));
        chk("midrun_reset_ledr", 32'(bus.LEDR), 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
